// File: rtl/mlp_layer_sequencer_if.sv
// Engine launch/completion port and result handshake of the layer sequencer.
interface mlp_layer_sequencer_if #(
  parameter int MAX_LAYERS = 8,
  parameter int DIM_W      = 10,
  parameter int IDX_W      = 4
);
  localparam int LW = $clog2(MAX_LAYERS);

  logic             eng_start;
  logic [1:0]       eng_op;
  logic [LW-1:0]    eng_layer;
  logic [DIM_W-1:0] eng_k;
  logic [DIM_W-1:0] eng_n;
  logic             eng_done;
  logic [IDX_W-1:0] argmax_idx;
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] result_class;

  modport master (
    output eng_start, eng_op, eng_layer, eng_k, eng_n, result_valid, result_class,
    input  eng_done, argmax_idx, result_ready
  );

  modport slave (
    input  eng_start, eng_op, eng_layer, eng_k, eng_n, result_valid, result_class,
    output eng_done, argmax_idx, result_ready
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Control FSM that walks a layer table, issuing MM / ReLU / argmax ops to a
// shared engine, with abort, watchdog, result handshake and busy-cycle count.
module mlp_layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int DIM_W      = 10,
  parameter int IDX_W      = 4,
  parameter int TO_W       = 20,
  parameter int CYC_W      = 32,
  localparam int LW        = $clog2(MAX_LAYERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_layer,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic             cfg_relu,
  input  logic [LW:0]      num_layers,
  input  logic             start,
  input  logic             abort,
  mlp_layer_sequencer_if.master bus,
  output logic             busy,
  output logic             error,
  output logic [CYC_W-1:0] cycle_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MM_ISSUE   = 3'd1,
    MM_WAIT    = 3'd2,
    RELU_ISSUE = 3'd3,
    RELU_WAIT  = 3'd4,
    ARG_ISSUE  = 3'd5,
    ARG_WAIT   = 3'd6,
    RESULT     = 3'd7
  } state_t;

  state_t           cur;
  logic [DIM_W-1:0] tab_k [MAX_LAYERS];
  logic [DIM_W-1:0] tab_n [MAX_LAYERS];
  logic [MAX_LAYERS-1:0] tab_relu;
  logic [LW-1:0]    layer;
  logic [LW-1:0]    last;
  logic [TO_W-1:0]  wd;
  logic [TO_W-1:0]  wd_next;
  logic [LW:0]      nl_m1;
  logic [IDX_W-1:0] class_q;
  logic             start_ok;
  logic             in_wait;
  logic             timeout;

  assign start_ok = (num_layers != '0) && (num_layers <= (LW+1)'(MAX_LAYERS));
  assign nl_m1    = num_layers - 1'b1;
  assign in_wait  = (cur == MM_WAIT) || (cur == RELU_WAIT) || (cur == ARG_WAIT);
  assign wd_next  = wd + 1'b1;
  // The watchdog fires on the wait cycle whose increment would reach all-ones.
  assign timeout  = in_wait && !bus.eng_done && (wd_next == '1);

  assign busy              = (cur != IDLE) && (cur != RESULT);
  assign state             = cur;
  assign bus.result_valid  = (cur == RESULT);
  assign bus.result_class  = class_q;

  // Layer table: writable only while idle so a running pass sees stable dims.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        tab_k[i] <= '0;
        tab_n[i] <= '0;
      end
      tab_relu <= '0;
    end else if (cfg_we && cur == IDLE) begin
      tab_k[cfg_layer]    <= cfg_k;
      tab_n[cfg_layer]    <= cfg_n;
      tab_relu[cfg_layer] <= cfg_relu;
    end
  end

  // Engine command decode from the registered state and layer index.
  always_comb begin
    bus.eng_start = 1'b0;
    bus.eng_op    = 2'd0;
    bus.eng_layer = '0;
    bus.eng_k     = '0;
    bus.eng_n     = '0;
    case (cur)
      MM_ISSUE, MM_WAIT: begin
        bus.eng_start = (cur == MM_ISSUE);
        bus.eng_op    = 2'd0;
        bus.eng_layer = layer;
        bus.eng_k     = tab_k[layer];
        bus.eng_n     = tab_n[layer];
      end
      RELU_ISSUE, RELU_WAIT: begin
        bus.eng_start = (cur == RELU_ISSUE);
        bus.eng_op    = 2'd1;
        bus.eng_layer = layer;
        bus.eng_n     = tab_n[layer];
      end
      ARG_ISSUE, ARG_WAIT: begin
        bus.eng_start = (cur == ARG_ISSUE);
        bus.eng_op    = 2'd2;
        bus.eng_layer = last;
        bus.eng_n     = tab_n[last];
      end
      default: ;
    endcase
  end

  // Sequencer FSM with watchdog, sticky error, result capture and cycle count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      layer       <= '0;
      last        <= '0;
      wd          <= '0;
      error       <= 1'b0;
      class_q     <= '0;
      cycle_count <= '0;
    end else begin
      if (busy && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (busy && abort) begin
        cur <= IDLE;
      end else begin
        case (cur)
          IDLE: begin
            if (start) begin
              if (start_ok) begin
                cur         <= MM_ISSUE;
                layer       <= '0;
                last        <= nl_m1[LW-1:0];
                error       <= 1'b0;
                cycle_count <= '0;
              end else begin
                error <= 1'b1;
              end
            end
          end
          MM_ISSUE:   begin wd <= '0; cur <= MM_WAIT;   end
          RELU_ISSUE: begin wd <= '0; cur <= RELU_WAIT; end
          ARG_ISSUE:  begin wd <= '0; cur <= ARG_WAIT;  end
          MM_WAIT: begin
            wd <= wd_next;
            if (timeout) begin
              error <= 1'b1;
              cur   <= IDLE;
            end else if (bus.eng_done) begin
              if (tab_relu[layer]) begin
                cur <= RELU_ISSUE;
              end else if (layer == last) begin
                cur <= ARG_ISSUE;
              end else begin
                layer <= layer + 1'b1;
                cur   <= MM_ISSUE;
              end
            end
          end
          RELU_WAIT: begin
            wd <= wd_next;
            if (timeout) begin
              error <= 1'b1;
              cur   <= IDLE;
            end else if (bus.eng_done) begin
              if (layer == last) begin
                cur <= ARG_ISSUE;
              end else begin
                layer <= layer + 1'b1;
                cur   <= MM_ISSUE;
              end
            end
          end
          ARG_WAIT: begin
            wd <= wd_next;
            if (timeout) begin
              error <= 1'b1;
              cur   <= IDLE;
            end else if (bus.eng_done) begin
              class_q <= bus.argmax_idx;
              cur     <= RESULT;
            end
          end
          RESULT: begin
            if (bus.result_ready) cur <= IDLE;
          end
          default: cur <= IDLE;
        endcase
      end
    end
  end

endmodule
